// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared definitions for the memory-side bus controller.
//   - MMIO register offsets relative to the MMIO base address
//   - controller state encoding (plain constants so legacy code can match on them)
//   - region-decode enum and the decode helper used by the controller
package mem_map_pkg;

  localparam logic [31:0] MMIO_LED_OFS = 32'h0000_0000;
  localparam logic [31:0] MMIO_CNT_OFS = 32'h0000_0004;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_MMIO = 2'd1,
    RGN_ERR  = 2'd2
  } region_e;

  // Misalignment and conflicting strobes fault before any region match, so a
  // faulting request can never reach the RAM or an MMIO register.
  function automatic region_e decode_region(
    input logic [31:0] addr,
    input logic        rd,
    input logic        wr,
    input logic        mmio_hit,
    input int unsigned ram_aw
  );
    logic in_ram;
    in_ram = ((addr >> (ram_aw + 2)) == 32'd0);
    if ((addr[1:0] != 2'b00) || (rd && wr)) return RGN_ERR;
    if (in_ram)                             return RGN_RAM;
    if (mmio_hit)                           return RGN_MMIO;
    return RGN_ERR;
  endfunction

endpackage

// File: rtl/mmio_regs.sv
// mmio_regs: MMIO register block of the bus controller.
//   LED register at MMIO_BASE+0 (8 bits) and a free-running 32-bit cycle
//   counter at MMIO_BASE+4 that loads on write instead of incrementing.
// Ports:
//   iClk, iRst  clock, synchronous active-high reset
//   iAddr       byte address of the current request
//   iWe         write strobe (one cycle, only for a decoded MMIO write)
//   iWData      write data
//   oHit        iAddr selects one of the MMIO registers
//   oRData      combinational read mux, current register contents
//   oLed        LED register
module mmio_regs
  import mem_map_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iAddr,
  input  logic        iWe,
  input  logic [31:0] iWData,
  output logic        oHit,
  output logic [31:0] oRData,
  output logic [7:0]  oLed
);

  logic        w_sel_led;
  logic        w_sel_cnt;
  logic [7:0]  r_led;
  logic [31:0] r_cnt;

  assign w_sel_led = (iAddr == (MMIO_BASE + MMIO_LED_OFS));
  assign w_sel_cnt = (iAddr == (MMIO_BASE + MMIO_CNT_OFS));
  assign oHit      = w_sel_led | w_sel_cnt;
  assign oLed      = r_led;

  always_comb begin
    oRData = '0;
    if (w_sel_led)      oRData = {24'b0, r_led};
    else if (w_sel_cnt) oRData = r_cnt;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_led <= '0;
    end else if (iWe && w_sel_led) begin
      r_led <= iWData[7:0];
    end
  end

  // A counter write replaces that cycle's increment; wrap is natural overflow.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cnt <= '0;
    end else if (iWe && w_sel_cnt) begin
      r_cnt <= iWData;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory-side bus controller behind the multicycle processor.
//   Serves each held read/write request from a synchronous single-port word
//   RAM or the MMIO block, then returns registered read data and a one-cycle
//   ready pulse (with error flag for faulting requests).
// Ports:
//   iClk, iRst           clock, synchronous active-high reset
//   iMemAddr/iMemData    processor byte address / write data
//   iMemRead/iMemWrite   request strobes, held until oRdy
//   oMemData             registered read data
//   oRdy, oErr           completion pulse, fault flag alongside it
//   oRamAddr/oRamWData   RAM word address / write data
//   oRamEn, oRamWe       RAM enable (one cycle per access), write enable
//   iRamRData            RAM read data, valid the cycle after oRamEn
//   oLed                 LED register
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_AW      = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [31:0]       iMemAddr,
  input  logic [31:0]       iMemData,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  output logic [31:0]       oMemData,
  output logic              oRdy,
  output logic              oErr,
  output logic [RAM_AW-1:0] oRamAddr,
  output logic [31:0]       oRamWData,
  output logic              oRamEn,
  output logic              oRamWe,
  input  logic [31:0]       iRamRData,
  output logic [7:0]        oLed
);

  logic [2:0]        r_state;
  logic [3:0]        r_wait;
  logic              r_write;
  logic [31:0]       r_mem_data;
  logic              r_rdy;
  logic              r_err;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic              r_ram_en;
  logic              r_ram_we;

  logic              w_req;
  logic              w_mmio_hit;
  logic [31:0]       w_mmio_rdata;
  logic              w_mmio_we;
  region_e           w_rgn;

  assign w_req = iMemRead | iMemWrite;
  assign w_rgn = decode_region(iMemAddr, iMemRead, iMemWrite, w_mmio_hit, RAM_AW);

  // MMIO requests are decoded and completed in the IDLE cycle itself, so the
  // register block sees the live request rather than a latched copy.
  assign w_mmio_we = (r_state == ST_IDLE) && w_req && (w_rgn == RGN_MMIO) && iMemWrite;

  mmio_regs #(
    .MMIO_BASE (MMIO_BASE)
  ) u_mmio (
    .iClk   (iClk),
    .iRst   (iRst),
    .iAddr  (iMemAddr),
    .iWe    (w_mmio_we),
    .iWData (iMemData),
    .oHit   (w_mmio_hit),
    .oRData (w_mmio_rdata),
    .oLed   (oLed)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_write     <= 1'b0;
      r_mem_data  <= '0;
      r_rdy       <= 1'b0;
      r_err       <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
    end else begin
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_write <= iMemWrite;
            case (w_rgn)
              RGN_ERR: begin
                r_mem_data <= '0;
                r_rdy      <= 1'b1;
                r_err      <= 1'b1;
                r_state    <= ST_DONE;
              end
              RGN_MMIO: begin
                if (!iMemWrite) r_mem_data <= w_mmio_rdata;
                r_rdy   <= 1'b1;
                r_state <= ST_DONE;
              end
              default: begin
                // RAM strobes are registered here so they are high for
                // exactly the ACCESS cycle.
                r_ram_en    <= 1'b1;
                r_ram_we    <= iMemWrite;
                r_ram_addr  <= iMemAddr[RAM_AW+1:2];
                r_ram_wdata <= iMemData;
                r_state     <= ST_ACCESS;
              end
            endcase
          end
        end
        ST_ACCESS: begin
          r_wait  <= '0;
          r_state <= (WAIT_STATES > 0) ? ST_WAIT : ST_SAMPLE;
        end
        ST_WAIT: begin
          if (r_wait == 4'(WAIT_STATES - 1)) begin
            r_wait  <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (!r_write) r_mem_data <= iRamRData;
          r_rdy   <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oMemData  = r_mem_data;
  assign oRdy      = r_rdy;
  assign oErr      = r_err;
  assign oRamAddr  = r_ram_addr;
  assign oRamWData = r_ram_wdata;
  assign oRamEn    = r_ram_en;
  assign oRamWe    = r_ram_we;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (0 and 3 wait states) behind small
// word RAMs, with a transaction-level expectation model and literal checks.
module tb_mem_bus_ctrl;

  localparam int unsigned AW        = 8;
  localparam logic [31:0] BASE      = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BYTES = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   in_rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  logic [31:0]   addr_s [2];
  logic [31:0]   wd_s   [2];
  logic          rd_s   [2];
  logic          wr_s   [2];
  logic [31:0]   mdata_o[2];
  logic          rdy_o  [2];
  logic          err_o  [2];
  logic [AW-1:0] raddr_o[2];
  logic [31:0]   rwd_o  [2];
  logic          ren_o  [2];
  logic          rwe_o  [2];
  logic [31:0]   rrd    [2];
  logic [7:0]    led_o  [2];

  int ws [2] = '{0, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_ctrl #(.RAM_AW(AW), .WAIT_STATES(0), .MMIO_BASE(BASE)) u_ws0 (
    .iClk(clk), .iRst(rst), .iMemAddr(addr_s[0]), .iMemData(wd_s[0]),
    .iMemRead(rd_s[0]), .iMemWrite(wr_s[0]), .oMemData(mdata_o[0]),
    .oRdy(rdy_o[0]), .oErr(err_o[0]), .oRamAddr(raddr_o[0]), .oRamWData(rwd_o[0]),
    .oRamEn(ren_o[0]), .oRamWe(rwe_o[0]), .iRamRData(rrd[0]), .oLed(led_o[0]));

  mem_bus_ctrl #(.RAM_AW(AW), .WAIT_STATES(3), .MMIO_BASE(BASE)) u_ws3 (
    .iClk(clk), .iRst(rst), .iMemAddr(addr_s[1]), .iMemData(wd_s[1]),
    .iMemRead(rd_s[1]), .iMemWrite(wr_s[1]), .oMemData(mdata_o[1]),
    .oRdy(rdy_o[1]), .oErr(err_o[1]), .oRamAddr(raddr_o[1]), .oRamWData(rwd_o[1]),
    .oRamEn(ren_o[1]), .oRamWe(rwe_o[1]), .iRamRData(rrd[1]), .oLed(led_o[1]));

  // Synchronous RAMs seen by the two instances.
  logic [31:0] ram [2][256];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ren_o[d]) begin
        rrd[d] <= ram[d][raddr_o[d]];
        if (rwe_o[d]) ram[d][raddr_o[d]] <= rwd_o[d];
      end
    end
  end

  // Expectation model: per instance, what each output must be on a given cycle.
  logic [31:0]   mmem     [2][256];
  logic [7:0]    led_old  [2];
  logic [7:0]    led_new  [2];
  int            led_upd  [2];
  logic [31:0]   rd_old   [2];
  logic [31:0]   rd_pend  [2];
  int            exp_rdy  [2];
  logic          exp_err  [2];
  int            exp_en   [2];
  logic [AW-1:0] en_addr  [2];
  logic          en_we    [2];
  logic [31:0]   en_wd    [2];
  logic [31:0]   cnt_base [2];
  int            cnt_cyc  [2];
  int            last_rdy [2];

  function automatic logic [7:0] led_at(input int d, input int c);
    return (led_upd[d] >= 0 && c >= led_upd[d]) ? led_new[d] : led_old[d];
  endfunction

  function automatic logic [31:0] rdata_at(input int d, input int c);
    return (exp_rdy[d] >= 0 && c >= exp_rdy[d]) ? rd_pend[d] : rd_old[d];
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
    end
  endtask

  // Per-cycle compare, sampled on the falling edge.
  initial begin : cmp
    bit rdy_e;
    bit en_e;
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        for (int d = 0; d < 2; d++) begin
          rdy_e = (cyc == exp_rdy[d]);
          en_e  = (cyc == exp_en[d]);
          check("rdy", d, rdy_o[d], rdy_e);
          check("err", d, err_o[d], rdy_e && exp_err[d]);
          check("mem_data", d, mdata_o[d], rdata_at(d, cyc));
          check("led", d, led_o[d], led_at(d, cyc));
          check("ram_en", d, ren_o[d], en_e);
          if (en_e) begin
            check("ram_addr", d, raddr_o[d], en_addr[d]);
            check("ram_we", d, rwe_o[d], en_we[d]);
            if (en_we[d]) check("ram_wdata", d, rwd_o[d], en_wd[d]);
          end
        end
      end
    end
  end

  // Called at negedge+1; the request is taken by the DUT at the end of cycle
  // cyc+t_off (t_off=1 when the DUT is currently in its ready cycle).
  task automatic start_req(input int d, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int t_off, output int T);
    bit in_ram, is_led, is_cnt, err;
    int lat;
    logic [AW-1:0] w;
    T = cyc + t_off;
    led_old[d] = led_at(d, T);
    rd_old[d]  = rdata_at(d, T);
    led_new[d] = led_old[d];
    led_upd[d] = -1;
    in_ram = (a < RAM_BYTES);
    is_led = (a == BASE);
    is_cnt = (a == BASE + 32'd4);
    err    = (a[1:0] != 2'b00) || (rd && wr) || !(in_ram || is_led || is_cnt);
    lat    = (err || !in_ram) ? 1 : 3 + ws[d];
    w      = a[AW+1:2];
    exp_rdy[d] = T + lat;
    exp_err[d] = err;
    exp_en[d]  = (!err && in_ram) ? T + 1 : -1;
    en_addr[d] = w;
    en_we[d]   = wr;
    en_wd[d]   = wd;
    if (err)          rd_pend[d] = 32'd0;
    else if (!rd)     rd_pend[d] = rd_old[d];
    else if (in_ram)  rd_pend[d] = mmem[d][w];
    else if (is_led)  rd_pend[d] = {24'd0, led_old[d]};
    else              rd_pend[d] = cnt_base[d] + 32'(T - cnt_cyc[d]);
    if (!err && wr) begin
      if (in_ram) mmem[d][w] = wd;
      else if (is_led) begin
        led_new[d] = wd[7:0];
        led_upd[d] = T + 1;
      end else begin
        cnt_base[d] = wd;
        cnt_cyc[d]  = T + 1;
      end
    end
    addr_s[d] = a;
    wd_s[d]   = wd;
    rd_s[d]   = rd;
    wr_s[d]   = wr;
  endtask

  task automatic wait_rdy(input int d, input int T, input int lit_lat, input bit chk_data,
                          input logic [31:0] lit_data, input bit lit_err, input bit hold);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); #1;
      if (rdy_o[d]) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL rdy_timeout dut%0d actual=no_oRdy required=oRdy_within_40_cycles", d);
    end else begin
      check("latency_lit", d, cyc - T, lit_lat);
      check("err_lit", d, err_o[d], lit_err);
      if (chk_data) check("data_lit", d, mdata_o[d], lit_data);
      last_rdy[d] = cyc;
    end
    if (!hold) begin
      rd_s[d] = 1'b0;
      wr_s[d] = 1'b0;
      @(negedge clk); #1;
    end
  endtask

  task automatic xact(input int d, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input int lit_lat, input bit chk_data,
                      input logic [31:0] lit_data, input bit lit_err);
    int T;
    start_req(d, rd, wr, a, wd, 0, T);
    wait_rdy(d, T, lit_lat, chk_data, lit_data, lit_err, 1'b0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    in_rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 1'b0;
      wr_s[d] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      led_old[d]  = '0;
      led_new[d]  = '0;
      led_upd[d]  = -1;
      rd_old[d]   = '0;
      rd_pend[d]  = '0;
      exp_rdy[d]  = -1;
      exp_err[d]  = 1'b0;
      exp_en[d]   = -1;
      cnt_base[d] = '0;
      cnt_cyc[d]  = cyc;
    end
    in_rst = 1'b0;
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_rdy", d, rdy_o[d], 0);
      check("rst_err", d, err_o[d], 0);
      check("rst_mem_data", d, mdata_o[d], 0);
      check("rst_led", d, led_o[d], 0);
      check("rst_ram_en", d, ren_o[d], 0);
      check("rst_ram_we", d, rwe_o[d], 0);
      check("rst_ram_addr", d, raddr_o[d], 0);
      check("rst_ram_wdata", d, rwd_o[d], 0);
    end
  endtask

  initial begin
    int T;
    int r1;
    for (int d = 0; d < 2; d++) begin
      addr_s[d] = '0;
      wd_s[d]   = '0;
      rd_s[d]   = 1'b0;
      wr_s[d]   = 1'b0;
      last_rdy[d] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    do_reset();

    // RAM write then read, no wait states, then with three.
    xact(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 3, 0, 32'h0, 0);
    xact(0, 1, 0, 32'h10, 32'h0, 3, 1, 32'hDEAD_BEEF, 0);
    xact(1, 0, 1, 32'h10, 32'hDEAD_BEEF, 6, 0, 32'h0, 0);
    xact(1, 1, 0, 32'h10, 32'h0, 6, 1, 32'hDEAD_BEEF, 0);

    // Faults: misaligned, both strobes, outside both regions.
    xact(0, 1, 0, 32'h12, 32'h0, 1, 1, 32'h0, 1);
    xact(0, 1, 1, 32'h10, 32'h1234_5678, 1, 1, 32'h0, 1);
    xact(0, 1, 0, 32'h10, 32'h0, 3, 1, 32'hDEAD_BEEF, 0);
    xact(0, 1, 0, 32'h8000_0000, 32'h0, 1, 1, 32'h0, 1);
    xact(0, 1, 0, BASE + 32'd8, 32'h0, 1, 1, 32'h0, 1);
    xact(0, 0, 1, RAM_BYTES, 32'h5555_5555, 1, 1, 32'h0, 1);

    // LED write and readback.
    xact(0, 0, 1, BASE, 32'h0000_01A5, 1, 0, 32'h0, 0);
    check("led_lit", 0, led_o[0], 32'hA5);
    xact(0, 1, 0, BASE, 32'h0, 1, 1, 32'h0000_00A5, 0);

    // Counter load near the top, read three cycles later (wrapped to 0),
    // then a held back-to-back read two cycles after that.
    xact(0, 0, 1, BASE + 32'd4, 32'hFFFF_FFFE, 1, 0, 32'h0, 0);
    @(negedge clk); #1;
    start_req(0, 1, 0, BASE + 32'd4, 32'h0, 0, T);
    wait_rdy(0, T, 1, 1, 32'h0000_0000, 0, 1);
    start_req(0, 1, 0, BASE + 32'd4, 32'h0, 1, T);
    wait_rdy(0, T, 1, 1, 32'h0000_0002, 0, 0);

    // A few more RAM words on both instances.
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 2; d++) begin
        xact(d, 0, 1, 32'h40 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 3 + ws[d], 0, 32'h0, 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 2; d++) begin
        xact(d, 1, 0, 32'h40 + 32'(4 * i), 32'h0, 3 + ws[d], 1, 32'h1111_1111 * 32'(i + 1), 0);
      end
    end

    // Reset during the wait states of a RAM write.
    xact(1, 0, 1, BASE, 32'h0000_003C, 1, 0, 32'h0, 0);
    xact(1, 1, 0, 32'h10, 32'h0, 6, 1, 32'hDEAD_BEEF, 0);
    start_req(1, 0, 1, 32'h20, 32'h0000_55AA, 0, T);
    repeat (3) begin
      @(negedge clk); #1;
    end
    do_reset();
    repeat (6) begin
      @(negedge clk); #1;
    end
    xact(1, 1, 0, 32'h20, 32'h0, 6, 1, 32'h0000_55AA, 0);

    // Read strobe held across oRdy: second access follows immediately.
    start_req(0, 1, 0, 32'h44, 32'h0, 0, T);
    wait_rdy(0, T, 3, 1, 32'h2222_2222, 0, 1);
    r1 = last_rdy[0];
    start_req(0, 1, 0, 32'h44, 32'h0, 1, T);
    wait_rdy(0, T, 3, 1, 32'h2222_2222, 0, 0);
    check("b2b_gap", 0, last_rdy[0] - r1, 4);

    repeat (3) begin
      @(negedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
